// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, depth and pending-write entry type for the writeback queue
package regfile_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_match.sv
// regfile_wb_match: youngest-match search of occupied queue entries for one read address
module regfile_wb_match #(
  parameter int DEPTH = regfile_pkg::DEPTH,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W,
  localparam int PW = $clog2(DEPTH)
) (
  input  regfile_pkg::wb_entry_t mem [DEPTH],
  input  logic [PW-1:0]          head,
  input  logic [ADDR_W-1:0]      count,
  input  logic [ADDR_W-1:0]      addr,
  output logic                   hit,
  output logic [DATA_W-1:0]      data
);
  // walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i < int'(count) && mem[PW'(head + PW'(i))].addr == addr) begin
        hit = 1'b1;
        data = mem[PW'(head + PW'(i))].data;
      end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order pending-write FIFO in front of a register-file write port,
// with combinational youngest-value bypass for two read ports
module regfile_wb_queue #(
  parameter int DEPTH = regfile_pkg::DEPTH,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wr_grant,
  output logic              We,
  output logic [ADDR_W-1:0] W1,
  output logic [DATA_W-1:0] D1,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp1_data,
  output logic [DATA_W-1:0] byp2_data,
  output logic [ADDR_W-1:0] count,
  output logic              empty
);
  import regfile_pkg::*;
  localparam int PW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [ADDR_W-1:0] cnt;
  logic push;
  always_comb begin
    empty = cnt == '0;
    We = !empty && wr_grant;
    in_ready = (cnt < ADDR_W'(DEPTH)) || We;
    push = in_valid && in_ready;
    W1 = We ? mem[head].addr : '0;
    D1 = We ? mem[head].data : '0;
    count = cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (We) head <= head + 1'b1;
      if (push != We) cnt <= push ? cnt + 1'b1 : cnt - 1'b1;
    end
  // storage is left unreset; every reader qualifies it by occupancy
  always_ff @(posedge clk)
    if (push) mem[tail] <= '{addr: in_addr, data: in_data};
  regfile_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match1 (
    .mem(mem), .head(head), .count(cnt), .addr(R1), .hit(byp1_hit), .data(byp1_data)
  );
  regfile_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match2 (
    .mem(mem), .head(head), .count(cnt), .addr(R2), .hit(byp2_hit), .data(byp2_data)
  );
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed scenarios plus randomized traffic against a queue-based model
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW = 3;
  localparam int DW = 32;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  logic clk = 1'b0, rst_n, in_valid, in_ready, wr_grant, We, byp1_hit, byp2_hit, empty;
  logic [AW-1:0] in_addr, W1, R1, R2, count;
  logic [DW-1:0] in_data, D1, byp1_data, byp2_data;
  int n_checks = 0, n_fail = 0;
  ent_t q[$];
  always #5 clk = ~clk;
  regfile_wb_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .wr_grant(wr_grant), .We(We), .W1(W1), .D1(D1), .R1(R1), .R2(R2),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data),
    .count(count), .empty(empty)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic g);
    in_valid = v;
    in_addr = a;
    in_data = d;
    wr_grant = g;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    R1 = '0;
    R2 = '0;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", empty); end
    n_checks++; if (We !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b want 0", We); end
    n_checks++; if (W1 !== 3'd0 || D1 !== 32'd0) begin n_fail++; $display("FAIL reset_w1d1 got %0d/%h want 0/0", W1, D1); end
    n_checks++; if (byp1_hit !== 1'b0 || byp2_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %0b%0b want 00", byp1_hit, byp2_hit); end
    n_checks++; if (byp1_data !== 32'd0 || byp2_data !== 32'd0) begin n_fail++; $display("FAIL reset_bypdata got %h/%h want 0/0", byp1_data, byp2_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    tick;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic test_single;
    drive(1'b1, 3'd3, 32'hAAAAAAAA, 1'b1);
    #1;
    n_checks++; if (We !== 1'b0) begin n_fail++; $display("FAIL single_no_same_cycle got %0b want 0", We); end
    tick;
    drive(1'b0, '0, '0, 1'b1);
    #1;
    n_checks++; if (We !== 1'b1 || W1 !== 3'd3 || D1 !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL single_write got %0b/%0d/%h want 1/3/aaaaaaaa", We, W1, D1); end
    tick;
    n_checks++; if (empty !== 1'b1 || We !== 1'b0) begin n_fail++; $display("FAIL single_drained got empty=%0b we=%0b want 1/0", empty, We); end
  endtask
  task automatic test_fill_bypass;
    logic [AW-1:0] fa [4] = '{3'd1, 3'd2, 3'd1, 3'd5};
    logic [DW-1:0] fd [4] = '{32'h11, 32'h22, 32'h33, 32'h55};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fa[i], fd[i], 1'b0);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got %0b want 1", i, in_ready); end
      tick;
    end
    drive(1'b0, '0, '0, 1'b0);
    R1 = 3'd1;
    R2 = 3'd4;
    #1;
    n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got count=%0d ready=%0b want 4/0", count, in_ready); end
    n_checks++; if (byp1_hit !== 1'b1 || byp1_data !== 32'h33) begin n_fail++; $display("FAIL byp1_youngest got %0b/%h want 1/33", byp1_hit, byp1_data); end
    n_checks++; if (byp2_hit !== 1'b0 || byp2_data !== 32'h0) begin n_fail++; $display("FAIL byp2_miss got %0b/%h want 0/0", byp2_hit, byp2_data); end
  endtask
  task automatic test_full_reject;
    drive(1'b1, 3'd7, 32'hFF, 1'b0);
    R1 = 3'd7;
    R2 = 3'd5;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reject_ready got %0b want 0", in_ready); end
    tick;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL reject_count got %0d want 4", count); end
    n_checks++; if (byp1_hit !== 1'b0) begin n_fail++; $display("FAIL reject_not_stored got %0b want 0", byp1_hit); end
    n_checks++; if (byp2_hit !== 1'b1 || byp2_data !== 32'h55) begin n_fail++; $display("FAIL reject_intact got %0b/%h want 1/55", byp2_hit, byp2_data); end
  endtask
  task automatic test_back_to_back;
    logic [AW-1:0] ea [8] = '{3'd1, 3'd2, 3'd1, 3'd5, 3'd0, 3'd6, 3'd6, 3'd3};
    logic [DW-1:0] ed [8] = '{32'h11, 32'h22, 32'h33, 32'h55, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, ea[i+4], ed[i+4], 1'b1);
      else drive(1'b0, '0, '0, 1'b1);
      #1;
      n_checks++; if (We !== 1'b1 || W1 !== ea[i] || D1 !== ed[i]) begin n_fail++; $display("FAIL b2b_write[%0d] got %0b/%0d/%h want 1/%0d/%h", i, We, W1, D1, ea[i], ed[i]); end
      if (i < 4) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, in_ready); end
      end
      tick;
      n_checks++; if (count !== AW'(i < 4 ? 4 : 7 - i)) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want %0d", i, count, i < 4 ? 4 : 7 - i); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %0b want 1", empty); end
  endtask
  task automatic test_reset_midop;
    drive(1'b1, 3'd0, 32'hFFFFFFFF, 1'b0);
    R1 = 3'd0;
    tick;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    n_checks++; if (count !== 3'd1 || byp1_hit !== 1'b1 || byp1_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL r0_queued got %0d/%0b/%h want 1/1/ffffffff", count, byp1_hit, byp1_data); end
    #1;
    wr_grant = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (We !== 1'b0 || empty !== 1'b1 || byp1_hit !== 1'b0) begin n_fail++; $display("FAIL async_reset got we=%0b empty=%0b hit=%0b want 0/1/0", We, empty, byp1_hit); end
    tick;
    rst_n = 1'b1;
    #1;
    n_checks++; if (We !== 1'b0) begin n_fail++; $display("FAIL post_release_we got %0b want 0", We); end
    tick;
    n_checks++; if (We !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL post_release_idle got %0b/%0b want 0/1", We, empty); end
  endtask
  task automatic test_random;
    int sz, hits1, hits2;
    logic e_we, e_rdy, push;
    logic [AW-1:0] e_w1;
    logic [DW-1:0] e_d1, e_b1, e_b2;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 3) != 0), AW'($urandom), $urandom, 1'($urandom_range(0, 2) == 0));
      R1 = AW'($urandom);
      R2 = AW'($urandom);
      #1;
      sz = q.size();
      e_we = sz > 0 && wr_grant;
      e_w1 = e_we ? q[0].a : '0;
      e_d1 = e_we ? q[0].d : '0;
      e_rdy = sz < DEPTH || e_we;
      hits1 = 0;
      hits2 = 0;
      e_b1 = '0;
      e_b2 = '0;
      for (int i = 0; i < sz; i++) begin
        if (q[i].a == R1) begin hits1++; e_b1 = q[i].d; end
        if (q[i].a == R2) begin hits2++; e_b2 = q[i].d; end
      end
      n_checks++; if (count !== AW'(sz) || empty !== (sz == 0)) begin n_fail++; $display("FAIL rnd_count c%0d got %0d/%0b want %0d", c, count, empty, sz); end
      n_checks++; if (We !== e_we || W1 !== e_w1 || D1 !== e_d1) begin n_fail++; $display("FAIL rnd_write c%0d got %0b/%0d/%h want %0b/%0d/%h", c, We, W1, D1, e_we, e_w1, e_d1); end
      n_checks++; if (in_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d got %0b want %0b", c, in_ready, e_rdy); end
      n_checks++; if (byp1_hit !== (hits1 > 0) || byp1_data !== e_b1) begin n_fail++; $display("FAIL rnd_byp1 c%0d got %0b/%h want %0b/%h", c, byp1_hit, byp1_data, hits1 > 0, e_b1); end
      n_checks++; if (byp2_hit !== (hits2 > 0) || byp2_data !== e_b2) begin n_fail++; $display("FAIL rnd_byp2 c%0d got %0b/%h want %0b/%h", c, byp2_hit, byp2_data, hits2 > 0, e_b2); end
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1 || We !== 1'b0) begin n_fail++; $display("FAIL rnd_reset c%0d got %0b/%0b want 1/0", c, empty, We); end
        q.delete();
        tick;
        rst_n = 1'b1;
      end else begin
        push = in_valid && e_rdy;
        if (e_we) void'(q.pop_front());
        if (push) q.push_back('{a: in_addr, d: in_data});
        tick;
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_fill_bypass;
    test_full_reject;
    test_back_to_back;
    test_reset_midop;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of pending-write entries (power of two, at least 2).
REQ-002 Parameter: ADDR_W, 3, register address width (8 registers).
REQ-003 Parameter: DATA_W, 32, register data width.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: in_valid  in  1  producer offers a write result.
REQ-008 Port: in_ready  out  1  queue can accept the offered write this cycle.
REQ-009 Port: in_addr  in  ADDR_W  destination register of the offered write.
REQ-010 Port: in_data  in  DATA_W  value of the offered write.
REQ-011 Port: wr_grant  in  1  register-file write port is available this cycle.
REQ-012 Port: We  out  1  write enable to the register file.
REQ-013 Port: W1  out  ADDR_W  write address to the register file.
REQ-014 Port: D1  out  DATA_W  write data to the register file.
REQ-015 Port: R1, R2  in  ADDR_W  read addresses currently presented to the register file.
REQ-016 Port: byp1_hit, byp2_hit  out  1  a pending write matches R1 or R2.
REQ-017 Port: byp1_data, byp2_data  out  DATA_W  youngest pending value for R1 or R2; 0 when there is no hit.
REQ-018 Port: count  out  ADDR_W  number of occupied entries (0..DEPTH).
REQ-019 Port: empty  out  1  count == 0.

Function
REQ-020 The queue SHALL be an in-order FIFO of (addr, data) entries.
- push = in_valid && in_ready.
- pop = We.
REQ-021 We SHALL equal !empty && wr_grant, combinationally.
- W1/D1 SHALL present the head entry when We=1 and 0 when We=0.
- The register file commits the write at the same edge that pops the entry.
REQ-022 in_ready SHALL equal (count < DEPTH) || We.
- This is combinational from wr_grant.
- Push and pop in the same cycle when full is legal; count stays at DEPTH.
REQ-023 Minimum latency SHALL be one cycle: an entry pushed at edge N may appear on We/W1/D1 no earlier than the cycle after edge N.
- This holds even when the queue was empty with wr_grant=1.
REQ-024 Count update per edge:
- +1 on push only.
- -1 on pop only.
- Unchanged on both or neither.
- Pointers SHALL wrap modulo DEPTH.
REQ-025 in_valid while in_ready=0 SHALL be ignored; no state change and no data loss of existing entries.
REQ-026 Bypass:
- byp1_hit SHALL be 1 if any occupied entry, including the head being popped this cycle, has addr == R1.
- byp1_data SHALL be the data of the youngest such entry.
- R2/byp2 SHALL behave identically.
- Bypass is combinational and SHALL NOT see the entry being pushed this cycle.
REQ-027 Register 0 SHALL be an ordinary register: it is queued, written and bypassed like any other.
REQ-028 Duplicate addresses in the queue SHALL all be written, in order; none are merged or dropped.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear pointers and count, independent of clk.
- Outputs during reset: empty=1, We=0, W1=0, D1=0, byp*_hit=0, byp*_data=0, in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all pending entries; no write is issued in the cycle after reset release unless a push occurred.
REQ-031 Entry storage need not be reset; all outputs derived from storage SHALL be qualified by occupancy.

Structure
REQ-032 Package regfile_pkg SHALL hold ADDR_W, DATA_W, DEPTH defaults and the wb_entry_t typedef (addr, data).
REQ-033 Sub-module regfile_wb_match SHALL perform the youngest-match search (address in, hit and data out).
- It is instantiated once per read port.

Verification
REQ-034 Reset, then push (3, 0xAAAAAAAA) with wr_grant=1 -> next cycle We=1, W1=3, D1=0xAAAAAAAA; the following cycle empty=1.
REQ-035 wr_grant=0; push (1, 0x11), (2, 0x22), (1, 0x33), (5, 0x55) -> count=4, in_ready=0; R1=1 gives byp1_hit=1, byp1_data=0x33; R2=4 gives byp2_hit=0, byp2_data=0.
REQ-036 Full queue with in_valid=1, wr_grant=1 -> push and pop in the same cycle, count stays 4, writes issue in order 1, 2, 1, 5 with data 0x11, 0x22, 0x33, 0x55.
REQ-037 Full queue with wr_grant=0 and in_valid=1 with (7, 0xFF) -> entry rejected, count=4, existing contents unchanged.
REQ-038 Queue 0xFFFFFFFF to register 0; assert rst_n=0 between edges -> We=0, empty=1 immediately; no write to register 0 after release.
